moore_seq_det: RTL
==================

# moore_seq_det

Parametrised Moore-type serial sequence detector: the next generation of the team's fixed-pattern 1011 detector. The pattern and its width are elaboration-time parameters. An overlap-mode parameter selects overlapping or non-overlapping detection. A bit-qualifying enable supports gapped input streams, and an optional saturating match counter is available. It sits on a serial input stream as a reusable pattern-detect leaf.

## Interface
- PAT_W, 4: pattern length in bits, 2..16.
- PATTERN, 4'b1011: pattern bits; MSB is received first.
- OVERLAP, 1: 1 = overlapping detection, 0 = restart after each match.
- CNT_W, 8: match counter width, 1..32.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, reset is asynchronous and active-high.
- en  input  1  qualifies xin; state advances only on edges where en=1.
- xin  input  1  serial data bit.
- clr_cnt  input  1  synchronous clear of match_cnt.
- zout  output  1  Moore match flag.
- match_cnt  output  CNT_W  number of matches, saturating.

## Operation
- State ps holds the count of pattern bits currently matched, 0..PAT_W.
  - Width is SW = $clog2(PAT_W+1).
  - S_FULL = PAT_W.
- zout is decoded from ps only: zout = (ps == S_FULL). It never depends on xin.
- On an edge with en=1, ps becomes ns:
  - From ps < S_FULL: ns = delta(ps, xin). delta is the KMP automaton of PATTERN: the longest prefix of PATTERN that is a suffix of the matched prefix followed by xin.
  - From S_FULL with OVERLAP=1: ns = delta(B, xin), where B is the longest proper border of PATTERN.
  - From S_FULL with OVERLAP=0: ns = delta(0, xin).
- en=0: ps holds, so zout holds.
- Every transition into S_FULL is one match.
- Counter, when compiled in:
  - match_cnt increments on the edge where ns==S_FULL and en=1.
  - It saturates at 2^CNT_W-1.
  - clr_cnt has priority over an increment on the same edge; the result is 0.
  - clr_cnt is honoured regardless of en.
- rst, asynchronous: ps=0, zout=0 and match_cnt=0 immediately. An in-progress partial match is discarded.
- PATTERN bits above PAT_W-1 are ignored.

## Timing
- Match latency: the last pattern bit is sampled at edge k. zout is high from just after edge k until the next en=1 edge.
- With continuous en, each zout pulse lasts one cycle. Back-to-back overlapping matches give zout high on consecutive cycles.
- match_cnt updates on the same edge as zout rises, so it is visible in the same cycle.
- Reset release is synchronous to clk. The first bit sampled is the one at the first rising edge with rst=0.

## Configuration
- SEQDET_COUNT_EN defined: the counter, clr_cnt logic and match_cnt register are built.
- SEQDET_COUNT_EN undefined:
  - match_cnt is tied to 0.
  - clr_cnt is ignored.
  - The port list is unchanged.
  - Detection behaviour is identical.

## Structure
- Package seq_det_pkg holds:
  - the function border_len(pattern, w);
  - the function next_state(pattern, w, state, bit) used to build the transition logic at elaboration;
  - the SW computation helper.
- Sub-module seq_match_counter: saturating counter with synchronous clear and increment.
  - Parameter CNT_W.
  - Instantiated only under SEQDET_COUNT_EN.
- Transition logic is a generate loop over states 0..PAT_W. There is no hand-written case per pattern.

## Test plan
- PATTERN=1011, OVERLAP=1, stream 1,0,1,1,0,1,1 with en=1 -> zout high after bits 4 and 7; match_cnt=2.
- Same stream, OVERLAP=0 -> zout high only after bit 4; match_cnt=1.
- PAT_W=3, PATTERN=111, OVERLAP=1, stream 1,1,1,1,1 -> zout high for 3 consecutive cycles after bits 3–5; match_cnt=3.
- PATTERN=1011, bits 1,0,1 then rst pulsed mid-cycle, then 1 -> zout and ps go to 0 at once; no match. Then 1,0,1,1 -> a single match.
- Gapped input 1,0,1,1 with en=0 for 2 cycles between each bit -> a single match. zout stays high until the next en=1 edge.
- CNT_W=2, six matches -> match_cnt saturates at 3. clr_cnt on the same edge as a 7th match -> match_cnt=0 and zout=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and elaboration-time helpers for the parametrised sequence detector.
// The helpers build the KMP transition table; they are not meant for runtime logic.
package seq_det_pkg;

  localparam int MAX_PAT_W = 16;

  typedef logic [MAX_PAT_W-1:0] pat_t;

  function automatic int sw_of(input int w);
    return $clog2(w + 1);
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic int border_len(input pat_t pattern, input int w);
    int  best;
    bit  ok;
    best = 0;
    for (int k = 1; k < w; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (pattern[w-1-j] != pattern[k-1-j]) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  // Matched prefix of length `state` (state < w) extended by bit b; returns the
  // longest pattern prefix that is a suffix of that string.
  function automatic int next_state(input pat_t pattern, input int w,
                                    input int state, input logic b);
    int   best;
    int   len;
    int   pos;
    bit   ok;
    logic sb;
    best = 0;
    len  = state + 1;
    for (int k = 1; k <= len; k++) begin
      if (k <= w) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          pos = len - k + j;
          sb  = (pos == state) ? b : pattern[w-1-pos];
          if (sb != pattern[w-1-j]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with synchronous clear; clear wins over increment.
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/moore_seq_det.sv
// Moore serial pattern detector driven by an elaboration-time KMP transition table.
// Define SEQDET_COUNT_EN to build the saturating match counter (else match_cnt is 0).
//
//   state      | meaning
//   0          | no pattern bits matched
//   1..PAT_W-1 | that many leading pattern bits matched
//   PAT_W      | full match, zout asserted
module moore_seq_det
  import seq_det_pkg::*;
#(
  parameter int   PAT_W   = 4,
  parameter pat_t PATTERN = 16'b1011,
  parameter int   OVERLAP = 1,
  parameter int   CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             xin,
  input  logic             clr_cnt,
  output logic             zout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int            SW     = sw_of(PAT_W);
  localparam int            NS     = 2 ** SW;
  localparam int            BORDER = border_len(PATTERN, PAT_W);
  localparam logic [SW-1:0] S_FULL = SW'(PAT_W);

  logic [SW-1:0] ps_q, ps_d;
  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];
  logic          hit;

  // Encodings above PAT_W are unreachable; they fall back to delta(0, xin).
  for (genvar s = 0; s < NS; s++) begin : g_state
    localparam int SRC = (s > PAT_W)  ? 0 :
                         (s == PAT_W) ? ((OVERLAP != 0) ? BORDER : 0) : s;
    localparam int N0  = next_state(PATTERN, PAT_W, SRC, 1'b0);
    localparam int N1  = next_state(PATTERN, PAT_W, SRC, 1'b1);
    assign nxt0[s] = SW'(N0);
    assign nxt1[s] = SW'(N1);
  end

  always_comb begin
    ps_d = ps_q;
    if (en) ps_d = xin ? nxt1[ps_q] : nxt0[ps_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ps_q <= '0;
    else     ps_q <= ps_d;
  end

  assign zout = (ps_q == S_FULL);
  assign hit  = en && (ps_d == S_FULL);

`ifdef SEQDET_COUNT_EN
  seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_cnt),
    .inc_i (hit),
    .cnt_o (match_cnt)
  );
`else
  logic unused_cnt_in;
  assign unused_cnt_in = ^{clr_cnt, hit};
  assign match_cnt     = '0;
`endif

endmodule
